// File: rtl/mr_bus_arb.sv
// Two-master pipelined Wishbone B4 arbiter: whole-CYC ownership, round-robin ties, outstanding-strobe limit.
// Optional ack watchdog enabled by defining MR_BUS_ARB_TIMEOUT_EN.
module mr_bus_arb #(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int MAX_OUT = 4
`ifdef MR_BUS_ARB_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_cyc_i,
    input  logic          a_stb_i,
    input  logic          a_we_i,
    input  logic [AW-1:0] a_adr_i,
    input  logic [DW-1:0] a_dat_i,
    input  logic [DW/8-1:0] a_sel_i,
    output logic          a_ack_o,
    output logic          a_err_o,
    output logic          a_stall_o,
    input  logic          b_cyc_i,
    input  logic          b_stb_i,
    input  logic          b_we_i,
    input  logic [AW-1:0] b_adr_i,
    input  logic [DW-1:0] b_dat_i,
    input  logic [DW/8-1:0] b_sel_i,
    output logic          b_ack_o,
    output logic          b_err_o,
    output logic          b_stall_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    input  logic          s_stall_i
);
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_OWN_A, S_OWN_B} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_last, w_last_nxt;     // 0 = A, 1 = B
    logic [CW-1:0] r_outcnt, w_outcnt_nxt;

    logic          w_own, w_is_b, w_full, w_ackev, w_acc, w_tmo;
    logic          w_m_cyc, w_m_stb;
    logic          w_stall, w_ack, w_err;

    assign w_own   = (r_state != S_IDLE);
    assign w_is_b  = (r_state == S_OWN_B);
    assign w_m_cyc = w_is_b ? b_cyc_i : a_cyc_i;
    assign w_m_stb = w_is_b ? b_stb_i : a_stb_i;
    assign w_full  = (r_outcnt == CW'(MAX_OUT));
    assign w_ackev = s_ack_i | s_err_i;
    assign w_acc   = s_stb_o & ~s_stall_i;

`ifdef MR_BUS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_tmo, w_tmo_nxt;
    logic          w_tmo_run;

    // Counts only while strobes are outstanding and the slave stays silent.
    assign w_tmo_run = w_own & (r_outcnt != '0) & ~w_ackev;
    assign w_tmo     = w_tmo_run & (r_tmo == TW'(TIMEOUT_CYC - 1));
    assign w_tmo_nxt = (w_tmo_run & ~w_tmo) ? r_tmo + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_tmo <= '0;
        else      r_tmo <= w_tmo_nxt;
    end
`else
    assign w_tmo = 1'b0;
`endif

    // Slave-side mux and response routing
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        w_stall   = 1'b1;
        w_ack     = 1'b0;
        w_err     = 1'b0;
        if (w_own) begin
            s_cyc_o = w_m_cyc & ~w_tmo;
            s_stb_o = w_m_cyc & w_m_stb & ~w_full & ~w_tmo;
            s_we_o  = w_is_b ? b_we_i  : a_we_i;
            s_adr_o = w_is_b ? b_adr_i : a_adr_i;
            s_dat_o = w_is_b ? b_dat_i : a_dat_i;
            s_sel_o = w_is_b ? b_sel_i : a_sel_i;
            w_stall = s_stall_i | w_full | w_tmo;
            w_ack   = s_ack_i;
            w_err   = s_err_i | w_tmo;
        end
        a_ack_o   = w_ack & ~w_is_b;
        a_err_o   = w_err & ~w_is_b;
        a_stall_o = w_is_b ? 1'b1 : w_stall;
        b_ack_o   = w_ack & w_is_b;
        b_err_o   = w_err & w_is_b;
        b_stall_o = w_is_b ? w_stall : 1'b1;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_last_nxt   = r_last;
        w_outcnt_nxt = r_outcnt;
        case (r_state)
            S_IDLE: begin
                if ((a_cyc_i & a_stb_i) && (b_cyc_i & b_stb_i))
                    w_state_nxt = r_last ? S_OWN_A : S_OWN_B;
                else if (a_cyc_i & a_stb_i)
                    w_state_nxt = S_OWN_A;
                else if (b_cyc_i & b_stb_i)
                    w_state_nxt = S_OWN_B;
            end
            S_OWN_A, S_OWN_B: begin
                if (!w_m_cyc || w_tmo) begin
                    w_state_nxt  = S_IDLE;
                    w_last_nxt   = w_is_b;
                    w_outcnt_nxt = '0;
                end else if (w_acc && !w_ackev) begin
                    w_outcnt_nxt = r_outcnt + 1'b1;
                end else if (!w_acc && w_ackev && r_outcnt != '0) begin
                    w_outcnt_nxt = r_outcnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b0;
            r_outcnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_last   <= w_last_nxt;
            r_outcnt <= w_outcnt_nxt;
        end
    end

endmodule
